// File: rtl/acumulador_ctrl_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, field widths,
// instruction layout and FSM encoding.
package acumulador_ctrl_pkg;

    localparam int unsigned OP_W          = 4;
    localparam int unsigned IMM_W         = 4;
    localparam int unsigned DATA_W        = 4;
    localparam int unsigned INSTR_W       = OP_W + IMM_W;
    localparam int unsigned MAX_INSTR_DEF = 16;
    localparam int unsigned CNT_W_DEF     = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
    localparam logic [OP_W-1:0] OP_LDA  = 4'd8;
    localparam logic [OP_W-1:0] OP_HALT = 4'd15;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IMM_W-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Opcodes 9..14 have no ULA meaning and only raise the error flag.
    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return (op > OP_LDA) && (op < OP_HALT);
    endfunction

endpackage

// File: rtl/acumulador_ctrl_if.sv
// Instruction stream, ULA bus and status bundle between the sequencer and its
// surroundings.
interface acumulador_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    import acumulador_ctrl_pkg::*;

    logic                start;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr_data;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OP_W-1:0]     alu_op;
    logic [DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]   acc;
    logic                busy;
    logic                done;
    logic                ovf;
    logic                err;
    logic [CNT_W-1:0]    instr_cnt;

    // Sequencer side.
    modport master (
        input  start, instr_valid, instr_data, alu_out,
        output instr_ready, alu_a, alu_b, alu_op, acc, busy, done, ovf, err, instr_cnt
    );

    // Environment side: instruction source, ULA and status observer.
    modport slave (
        output start, instr_valid, instr_data, alu_out,
        input  instr_ready, alu_a, alu_b, alu_op, acc, busy, done, ovf, err, instr_cnt
    );

endinterface

// File: rtl/acumulador_ctrl.sv
// Accumulator sequencer: fetches {op, imm} instructions, drives the external ULA
// with A = imm, B = acc, and writes the result back into acc.
module acumulador_ctrl
    import acumulador_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INSTR = MAX_INSTR_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    acumulador_ctrl_if.master  bus
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q,   acc_d;
    instr_t              ir_q,    ir_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                ovf_q,   ovf_d;
    logic                err_q,   err_d;
    logic                ready_q, ready_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.instr_valid && ready_q) begin
                    ir_d    = instr_t'(bus.instr_data);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ir_q.op == OP_HALT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_reserved(ir_q.op)) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = bus.alu_out;
                    end
                    // Signed overflow: operand signs vs. result sign, relative to acc.
                    if (ir_q.op == OP_ADD &&
                        acc_q[DATA_W-1] == ir_q.imm[IMM_W-1] &&
                        bus.alu_out[DATA_W-1] != acc_q[DATA_W-1]) begin
                        ovf_d = 1'b1;
                    end
                    if (ir_q.op == OP_SUB &&
                        acc_q[DATA_W-1] != ir_q.imm[IMM_W-1] &&
                        bus.alu_out[DATA_W-1] != acc_q[DATA_W-1]) begin
                        ovf_d = 1'b1;
                    end
                    state_d = (cnt_d == CNT_W'(MAX_INSTR)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_FETCH);
        busy_d  = (state_d == ST_FETCH) || (state_d == ST_EXEC);
        done_d  = (state_d == ST_DONE);
    end

    assign bus.instr_ready = ready_q;
    assign bus.alu_a       = ir_q.imm;
    assign bus.alu_b       = acc_q;
    assign bus.alu_op      = ir_q.op;
    assign bus.acc         = acc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ovf         = ovf_q;
    assign bus.err         = err_q;
    assign bus.instr_cnt   = cnt_q;

endmodule

// File: tb/tb_acumulador_ctrl.sv
// Directed bench for acumulador_ctrl with a behavioural ULA standing in for the
// real ALU beside it.
module tb_acumulador_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    acumulador_ctrl_if #(.CNT_W(5)) bus ();

    acumulador_ctrl #(.MAX_INSTR(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ULA: A = imm, B = acc, 4-bit two's complement.
    function automatic logic [3:0] ula(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
        logic [3:0] r;
        case (op)
            4'd0:    r = b + a;
            4'd1:    r = b - a;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~b;
            4'd6:    r = b << a;
            4'd7:    r = 4'($signed(b) >>> a);
            4'd8:    r = a;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    always_comb bus.alu_out = ula(bus.alu_op, bus.alu_a, bus.alu_b);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for ready, hands over one instruction, lets it execute.
    task automatic run_instr(input logic [7:0] data);
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_data  = data;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'h00;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        clk             = 1'b0;
        rst_n           = 1'b0;
        n_chk           = 0;
        n_fail          = 0;
        bus.start       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_acc",   32'(bus.acc),         32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_done",  32'(bus.done),        32'd0);
        chk("rst_cnt",   32'(bus.instr_cnt),   32'd0);
        chk("rst_flags", 32'({bus.ovf, bus.err}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid_ignored", 32'(bus.busy), 32'd0);

        // 1: LDA 3, ADD 2, SUB 1, HALT
        pulse_start();
        chk("t1_ready_after_start", 32'(bus.instr_ready), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        run_instr(8'h83);
        chk("t1_lda", 32'(bus.acc), 32'd3);
        run_instr(8'h02);
        chk("t1_add", 32'(bus.acc), 32'd5);
        run_instr(8'h11);
        chk("t1_sub", 32'(bus.acc), 32'd4);
        run_instr(8'hF0);
        chk("t1_done",   32'(bus.done),      32'd1);
        chk("t1_busy_d", 32'(bus.busy),      32'd0);
        chk("t1_cnt",    32'(bus.instr_cnt), 32'd3);
        chk("t1_flags",  32'({bus.ovf, bus.err}), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 32'd0);
        chk("t1_acc_held",   32'(bus.acc),  32'd4);

        // 2: LDA 7, ADD 1 overflows to -8; SUB 1 back to 7, ovf sticky
        pulse_start();
        chk("t2_acc_clr", 32'(bus.acc), 32'd0);
        run_instr(8'h87);
        chk("t2_lda", 32'(bus.acc), 32'd7);
        chk("t2_no_ovf", 32'(bus.ovf), 32'd0);
        run_instr(8'h01);
        chk("t2_add_wrap", 32'(bus.acc), 32'h8);
        chk("t2_ovf", 32'(bus.ovf), 32'd1);
        run_instr(8'h11);
        chk("t2_sub", 32'(bus.acc), 32'd7);
        chk("t2_ovf_sticky", 32'(bus.ovf), 32'd1);
        run_instr(8'hF0);
        tick();

        // 3: stall in FETCH with instr_valid low
        pulse_start();
        chk("t3_ovf_clr", 32'(bus.ovf), 32'd0);
        run_instr(8'h85);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_busy_stall",  32'(bus.busy),        32'd1);
        chk("t3_ready_stall", 32'(bus.instr_ready), 32'd1);
        chk("t3_acc_stall",   32'(bus.acc),         32'd5);
        run_instr(8'h01);
        chk("t3_resume", 32'(bus.acc), 32'd6);
        run_instr(8'hF0);
        chk("t3_cnt", 32'(bus.instr_cnt), 32'd2);
        tick();

        // 4: watchdog, 16 x ADD 1 without HALT
        pulse_start();
        for (int i = 0; i < 15; i++) run_instr(8'h01);
        chk("t4_cnt15",   32'(bus.instr_cnt),   32'd15);
        chk("t4_acc15",   32'(bus.acc),         32'hF);
        chk("t4_ready15", 32'(bus.instr_ready), 32'd1);
        chk("t4_ovf",     32'(bus.ovf),         32'd1);
        run_instr(8'h01);
        chk("t4_done",  32'(bus.done),        32'd1);
        chk("t4_cnt",   32'(bus.instr_cnt),   32'd16);
        chk("t4_wrap",  32'(bus.acc),         32'd0);
        chk("t4_ready", 32'(bus.instr_ready), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 8'h01;
        tick();
        chk("t4_idle_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        chk("t4_idle_busy", 32'(bus.busy), 32'd0);
        bus.instr_valid = 1'b0;

        // 5: reserved op, arithmetic shift, ignored starts, flag clear
        pulse_start();
        run_instr(8'hA0);
        chk("t5_err",     32'(bus.err),       32'd1);
        chk("t5_acc_res", 32'(bus.acc),       32'd0);
        chk("t5_cnt_res", 32'(bus.instr_cnt), 32'd1);
        run_instr(8'h8E);
        chk("t5_lda_neg", 32'(bus.acc), 32'hE);
        pulse_start();
        chk("t5_start_ign_acc", 32'(bus.acc),       32'hE);
        chk("t5_start_ign_err", 32'(bus.err),       32'd1);
        chk("t5_start_ign_cnt", 32'(bus.instr_cnt), 32'd2);
        run_instr(8'h71);
        chk("t5_shr", 32'(bus.acc), 32'hF);
        run_instr(8'hF0);
        chk("t5_done", 32'(bus.done), 32'd1);
        pulse_start();
        chk("t5_start_in_done", 32'(bus.busy), 32'd0);
        chk("t5_held_err",      32'(bus.err),  32'd1);
        chk("t5_held_acc",      32'(bus.acc),  32'hF);
        pulse_start();
        chk("t5_clr_err", 32'(bus.err),       32'd0);
        chk("t5_clr_acc", 32'(bus.acc),       32'd0);
        chk("t5_clr_cnt", 32'(bus.instr_cnt), 32'd0);
        chk("t5_fetch",   32'(bus.instr_ready), 32'd1);

        // 6: reset during EXEC of the second instruction
        run_instr(8'h83);
        chk("t6_lda", 32'(bus.acc), 32'd3);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 8'h02;
        tick();
        bus.instr_valid = 1'b0;
        chk("t6_in_exec", 32'(bus.instr_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_acc",  32'(bus.acc),       32'd0);
        chk("t6_busy", 32'(bus.busy),      32'd0);
        chk("t6_done", 32'(bus.done),      32'd0);
        chk("t6_cnt",  32'(bus.instr_cnt), 32'd0);
        tick();
        chk("t6_no_done", 32'(bus.done), 32'd0);
        chk("t6_idle",    32'(bus.instr_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
